seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Recovers BCD digits from a time-multiplexed seven-segment display bus: the inverse of the BCD-to-segment encoder used on the lab boards. It watches the one-hot digit-select and segment lines driven by a display scanner. It accepts each pattern only after it has been stable for a programmable number of cycles, then decodes it back to a 4-bit code. When every digit position has been captured, it publishes a complete multi-digit frame. It sits on the board-facing side of the counter labs as a self-check and readback block.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit positions (1–8)
- SETTLE_CYCLES, 4, consecutive identical samples required before a capture (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- digit_sel  input  NUM_DIGITS  one-hot active-high digit enable; bit i selects position i
- segments  input  7  segment lines, bit0=a … bit6=g, 1=lit
- digit_valid  output  1  one-cycle pulse per accepted capture
- digit_idx  output  3  position of the capture reported by digit_valid
- digit_code  output  4  decoded code of that capture
- frame_valid  output  1  one-cycle pulse when all positions have been captured
- bcd_out  output  4*NUM_DIGITS  frame value; nibble i = position i; held between frames
- frame_err  output  1  registered with frame_valid; 1 if any nibble in the frame is 4'hF

## Operation
- Input stage:
  - digit_sel and segments are registered once (sel_q, seg_q).
  - All logic uses the registered copies.
- Decode table (seg_q → code):
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
  - 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9
  - 0000000→4'hB (blank, not an error)
  - any other pattern→4'hF (invalid)
- FSM states are IDLE, SETTLE and HELD.
  - **IDLE:** sel_q is not one-hot (zero or multiple bits set). The count is held at 0. IDLE→SETTLE when sel_q is one-hot; the count is loaded with 1.
  - **SETTLE:** count increments while sel_q and seg_q equal their previous-cycle values. Any change reloads count=1 and stays in SETTLE, or goes to IDLE if sel_q is no longer one-hot. When count reaches SETTLE_CYCLES, a capture occurs and the FSM moves to HELD.
  - **HELD:** no further capture for the unchanged pattern. Any change to sel_q or seg_q goes to SETTLE with count=1, or to IDLE if sel_q is not one-hot.
- Capture actions:
  - Write the code into slot idx and set seen[idx].
  - Pulse digit_valid with digit_idx and digit_code.
  - Re-capturing an already-seen slot within a frame overwrites that slot; seen is unchanged.
- Frame completion:
  - Occurs when seen becomes all ones, counting the capture that completes it.
  - On the next edge: bcd_out←slots, frame_err←OR(slot==4'hF), frame_valid pulses, and seen clears.
  - A capture in that same cycle goes into the new frame.
- The settle count is clog2(SETTLE_CYCLES+1) bits wide and saturates; it never wraps.

## Timing
- Reset values:
  - digit_valid=0, digit_idx=0, digit_code=0
  - frame_valid=0, bcd_out=0, frame_err=0
  - seen=0, slots=0, FSM=IDLE, sel_q=0, seg_q=0
- rst asserted mid-settle or mid-frame discards all partial state on that edge. Outputs take reset values in the following cycle.
- Capture latency: inputs stable before edge k → digit_valid high in the cycle after edge k+SETTLE_CYCLES. That is SETTLE_CYCLES+1 edges: 1 input register plus SETTLE_CYCLES samples.
- frame_valid asserts one cycle after the digit_valid of the completing capture.
- The minimum spacing between digit_valid pulses is SETTLE_CYCLES cycles.
- A glitch of 1 cycle on either input restarts settling; it is never captured.

## Configuration
- SEG_ACTIVE_LOW_EN:
  - **Defined:** segments are inverted (common-anode panel, 0=lit) at the input register, before change detection and decoding.
  - **Undefined:** segments are used as-is (1=lit).
- digit_sel polarity is unaffected in both cases.

## Test plan
All scenarios use NUM_DIGITS=4 and SETTLE_CYCLES=4.
- Reset, then hold sel=0001 with segments=1001111 → digit_valid 5 cycles later with idx=0, code=3. Exactly one pulse, with no repeat while the inputs are held.
- Scan the positions 0→3 with 0,1011011(2),1101101(5),1111111(8) patterns, each 6 cycles → frame_valid once, bcd_out=16'h8520, frame_err=0.
- Present 1010101 on position 2 in an otherwise valid scan → digit_code=4'hF, nibble 2=F, frame_err=1.
- Hold a 1-cycle segments glitch, or sel=0110, for 3 cycles → no digit_valid; settling restarts afterward.
- Assert rst after 3 digits have been captured, then scan 4 digits → exactly one frame_valid, containing only the post-reset values.
- Compile with SEG_ACTIVE_LOW_EN and drive segments=1000000 → code 0. Drive 1111111 → code 4'hB.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan bus readback decoder
//
// Watches a multiplexed seven-segment bus and recovers the BCD digits.
// A pattern is captured once it has been stable for SETTLE_CYCLES samples.
// A frame is published once every digit position has been captured.
//
// Build option: SEG_ACTIVE_LOW_EN inverts segments at the input register
// (common-anode panel, 0=lit).
//
// Ports:
//    clk          rising-edge clock
//    rst          synchronous active-high reset
//    digit_sel    one-hot digit enable, bit i = position i
//    segments     segment lines, bit0=a .. bit6=g
//    digit_valid  one-cycle pulse per capture
//    digit_idx    position of the capture
//    digit_code   decoded code (0-9, B=blank, F=invalid)
//    frame_valid  one-cycle pulse when all positions have been captured
//    bcd_out      frame value, nibble i = position i, held between frames
//    frame_err    set with frame_valid when any nibble is F
module seg_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   digit_sel,
   input  logic [6:0]              segments,
   output logic                    digit_valid,
   output logic [2:0]              digit_idx,
   output logic [3:0]              digit_code,
   output logic                    frame_valid,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    frame_err
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           count_q, count_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d, sel_prev_q, sel_prev_d;
   logic [6:0]              seg_q, seg_d, seg_prev_q, seg_prev_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0] slots_q, slots_d;
   logic                    digit_valid_q, digit_valid_d;
   logic [2:0]              digit_idx_q, digit_idx_d;
   logic [3:0]              digit_code_q, digit_code_d;
   logic                    frame_valid_q, frame_valid_d;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic                    frame_err_q, frame_err_d;

   logic          sel_onehot;
   logic          changed;
   logic          capture;
   logic [CW-1:0] count_inc;
   logic [2:0]    cur_idx;
   logic [3:0]    cur_code;

   // Input register plus a one-cycle history used for change detection.
   always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
      seg_d = ~segments;
`else
      seg_d = segments;
`endif
      sel_d      = digit_sel;
      sel_prev_d = sel_q;
      seg_prev_d = seg_q;
   end

   always_comb begin
      case (seg_q)
         7'b0111111: cur_code = 4'h0;
         7'b0000110: cur_code = 4'h1;
         7'b1011011: cur_code = 4'h2;
         7'b1001111: cur_code = 4'h3;
         7'b1100110: cur_code = 4'h4;
         7'b1101101: cur_code = 4'h5;
         7'b1111101: cur_code = 4'h6;
         7'b0000111: cur_code = 4'h7;
         7'b1111111: cur_code = 4'h8;
         7'b1101111: cur_code = 4'h9;
         7'b0000000: cur_code = 4'hB;
         default:    cur_code = 4'hF;
      endcase
   end

   always_comb begin
      cur_idx = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_q[i]) cur_idx = 3'(i);
      end
   end

   assign sel_onehot = $onehot(sel_q);
   assign changed    = (sel_q != sel_prev_q) || (seg_q != seg_prev_q);
   assign count_inc  = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;

   // The cycle a one-hot pattern first appears counts as sample 1.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_onehot) begin
               state_d = SETTLE;
               count_d = CW'(1);
            end else begin
               count_d = '0;
            end
         end
         SETTLE: begin
            if (!sel_onehot) begin
               state_d = IDLE;
               count_d = '0;
            end else if (changed) begin
               count_d = CW'(1);
            end else begin
               count_d = count_inc;
               if (count_inc == CNT_MAX) begin
                  capture = 1'b1;
                  state_d = HELD;
               end
            end
         end
         HELD: begin
            if (changed) begin
               state_d = sel_onehot ? SETTLE : IDLE;
               count_d = sel_onehot ? CW'(1) : '0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // Frame publish runs before the capture update so that a capture landing
   // in the publish cycle starts the next frame rather than being lost.
   always_comb begin
      seen_d        = seen_q;
      slots_d       = slots_q;
      bcd_d         = bcd_q;
      frame_err_d   = frame_err_q;
      frame_valid_d = 1'b0;
      digit_valid_d = capture;
      digit_idx_d   = digit_idx_q;
      digit_code_d  = digit_code_q;
      if (&seen_q) begin
         frame_valid_d = 1'b1;
         bcd_d         = slots_q;
         seen_d        = '0;
         frame_err_d   = 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slots_q[4*i +: 4] == 4'hF) frame_err_d = 1'b1;
         end
      end
      if (capture) begin
         digit_idx_d  = cur_idx;
         digit_code_d = cur_code;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
               slots_d[4*i +: 4] = cur_code;
               seen_d[i]         = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         count_q       <= '0;
         sel_q         <= '0;
         seg_q         <= '0;
         sel_prev_q    <= '0;
         seg_prev_q    <= '0;
         seen_q        <= '0;
         slots_q       <= '0;
         digit_valid_q <= 1'b0;
         digit_idx_q   <= 3'd0;
         digit_code_q  <= 4'd0;
         frame_valid_q <= 1'b0;
         bcd_q         <= '0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         sel_q         <= sel_d;
         seg_q         <= seg_d;
         sel_prev_q    <= sel_prev_d;
         seg_prev_q    <= seg_prev_d;
         seen_q        <= seen_d;
         slots_q       <= slots_d;
         digit_valid_q <= digit_valid_d;
         digit_idx_q   <= digit_idx_d;
         digit_code_q  <= digit_code_d;
         frame_valid_q <= frame_valid_d;
         bcd_q         <= bcd_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign digit_valid = digit_valid_q;
   assign digit_idx   = digit_idx_q;
   assign digit_code  = digit_code_q;
   assign frame_valid = frame_valid_q;
   assign bcd_out     = bcd_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;
   localparam int ND = 4;
   localparam int SC = 4;
`ifdef SEG_ACTIVE_LOW_EN
   localparam logic [6:0] SEG_INV = 7'h7F;
`else
   localparam logic [6:0] SEG_INV = 7'h00;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [ND-1:0] digit_sel;
   logic [6:0]    seg_log;
   logic [6:0]    segments;
   logic          digit_valid;
   logic [2:0]    digit_idx;
   logic [3:0]    digit_code;
   logic          frame_valid;
   logic [4*ND-1:0] bcd_out;
   logic          frame_err;

   // seg_log is always the logical pattern (1=lit); the panel polarity is applied here.
   assign segments = seg_log ^ SEG_INV;

   seg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .digit_sel(digit_sel), .segments(segments),
      .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_code(digit_code),
      .frame_valid(frame_valid), .bcd_out(bcd_out), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [6:0] tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   function automatic logic [3:0] model_decode(input logic [6:0] p);
      if (p == 7'd0) return 4'hB;
      for (int d = 0; d < 10; d++) begin
         if (tbl[d] == p) return 4'(d);
      end
      return 4'hF;
   endfunction

   // Reference model: a capture happens when a one-hot sample has been seen
   // exactly SC times in a row; the digit pulse follows one cycle after the
   // last sample and the frame one cycle after the completing pulse.
   logic            started = 1'b0;
   logic [ND-1:0]   m_sel, m_prev_sel;
   logic [6:0]      m_seg, m_prev_seg;
   int              run;
   logic [3:0]      m_slot [ND];
   logic [ND-1:0]   m_seen;
   logic            exp_dv, exp_fv, exp_err;
   logic [2:0]      exp_idx;
   logic [3:0]      exp_code;
   logic [4*ND-1:0] exp_bcd;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            started = 1'b1;
            m_sel = '0; m_prev_sel = '0; m_seg = '0; m_prev_seg = '0;
            run = 0; m_seen = '0;
            for (int d = 0; d < ND; d++) m_slot[d] = 4'h0;
            exp_dv = 1'b0; exp_fv = 1'b0; exp_err = 1'b0; exp_bcd = '0;
            exp_idx = 3'd0; exp_code = 4'd0;
         end else begin
            exp_fv = 1'b0;
            if (m_seen == {ND{1'b1}}) begin
               exp_fv = 1'b1;
               exp_err = 1'b0;
               for (int d = 0; d < ND; d++) begin
                  exp_bcd[4*d +: 4] = m_slot[d];
                  if (m_slot[d] == 4'hF) exp_err = 1'b1;
               end
               m_seen = '0;
            end
            if (m_sel == m_prev_sel && m_seg == m_prev_seg) run = (run < 1000) ? run + 1 : run;
            else run = 1;
            exp_dv = 1'b0;
            if ($countones(m_sel) == 1 && run == SC) begin
               for (int d = 0; d < ND; d++) begin
                  if (m_sel[d]) begin
                     exp_idx = 3'(d);
                     exp_code = model_decode(m_seg);
                     m_slot[d] = exp_code;
                     m_seen[d] = 1'b1;
                  end
               end
               exp_dv = 1'b1;
            end
            m_prev_sel = m_sel;
            m_prev_seg = m_seg;
            m_sel = digit_sel;
            m_seg = seg_log;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("digit_valid", 32'(digit_valid), 32'(exp_dv));
            if (exp_dv) begin
               check("digit_idx", 32'(digit_idx), 32'(exp_idx));
               check("digit_code", 32'(digit_code), 32'(exp_code));
            end
            check("frame_valid", 32'(frame_valid), 32'(exp_fv));
            check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
            check("frame_err", 32'(frame_err), 32'(exp_err));
         end
      end
   end

   int              cyc, dv_cnt, fv_cnt, first_dv;
   logic [3:0]      dv_code [ND];
   logic [4*ND-1:0] last_bcd;
   logic            last_err;

   task automatic clear_counts();
      cyc = 0; dv_cnt = 0; fv_cnt = 0; first_dv = 0;
      last_bcd = '0; last_err = 1'b0;
      for (int d = 0; d < ND; d++) dv_code[d] = 4'hE;
   endtask

   // Called just after a negedge; applies inputs and observes n cycles.
   task automatic drive(input logic [ND-1:0] s, input logic [6:0] p, input int n);
      digit_sel = s;
      seg_log = p;
      repeat (n) begin
         @(negedge clk);
         cyc++;
         if (digit_valid === 1'b1) begin
            dv_cnt++;
            if (first_dv == 0) first_dv = cyc;
            if (digit_idx < 3'(ND)) dv_code[digit_idx[1:0]] = digit_code;
         end
         if (frame_valid === 1'b1) begin
            fv_cnt++;
            last_bcd = bcd_out;
            last_err = frame_err;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      digit_sel = '0;
      seg_log = '0;
      repeat (3) @(negedge clk);
      check("reset_idx", 32'(digit_idx), 32'h0);
      check("reset_code", 32'(digit_code), 32'h0);
      check("reset_bcd", 32'(bcd_out), 32'h0);
      rst = 1'b0;

      // Single capture latency and no repeat while held.
      clear_counts();
      drive(4'b0001, 7'b1001111, 15);
      check("lat_first_dv", 32'(first_dv), 32'd5);
      check("lat_dv_count", 32'(dv_cnt), 32'd1);
      check("lat_code", 32'(dv_code[0]), 32'h3);

      // Full scan 0,2,5,8.
      clear_counts();
      drive(4'b0001, 7'b0111111, 6);
      drive(4'b0010, 7'b1011011, 6);
      drive(4'b0100, 7'b1101101, 6);
      drive(4'b1000, 7'b1111111, 6);
      drive(4'b0000, 7'b0000000, 3);
      check("scan_fv_count", 32'(fv_cnt), 32'd1);
      check("scan_bcd", 32'(last_bcd), 32'h8520);
      check("scan_err", 32'(last_err), 32'h0);
      check("scan_dv_count", 32'(dv_cnt), 32'd4);

      // Invalid pattern on position 2.
      clear_counts();
      drive(4'b0001, 7'b0000111, 6);
      drive(4'b0010, 7'b0000110, 6);
      drive(4'b0100, 7'b1010101, 6);
      drive(4'b1000, 7'b1101111, 6);
      drive(4'b0000, 7'b0000000, 3);
      check("inv_code", 32'(dv_code[2]), 32'hF);
      check("inv_bcd", 32'(last_bcd), 32'h9F17);
      check("inv_err", 32'(last_err), 32'h1);

      // Glitches and a non-one-hot select never capture.
      clear_counts();
      drive(4'b0000, 7'b0000000, 2);
      drive(4'b0010, 7'b1100110, 3);
      drive(4'b0010, 7'b1100111, 1);
      drive(4'b0010, 7'b1100110, 3);
      drive(4'b0110, 7'b1100110, 3);
      check("glitch_no_dv", 32'(dv_cnt), 32'd0);
      drive(4'b0010, 7'b1100110, 6);
      check("glitch_recover_dv", 32'(dv_cnt), 32'd1);
      check("glitch_recover_code", 32'(dv_code[1]), 32'h4);

      // Reset mid-frame discards partial captures.
      drive(4'b0001, 7'b1111111, 6);
      drive(4'b0010, 7'b1111111, 6);
      drive(4'b0100, 7'b1111111, 6);
      rst = 1'b1;
      drive(4'b0000, 7'b0000000, 2);
      rst = 1'b0;
      clear_counts();
      drive(4'b0001, 7'b0000110, 6);
      drive(4'b0010, 7'b1101111, 6);
      drive(4'b0100, 7'b0000111, 6);
      drive(4'b1000, 7'b1100110, 6);
      drive(4'b0000, 7'b0000000, 3);
      check("rst_fv_count", 32'(fv_cnt), 32'd1);
      check("rst_bcd", 32'(last_bcd), 32'h4791);

`ifdef SEG_ACTIVE_LOW_EN
      // Physical levels 1000000 and 1111111 on a common-anode panel.
      clear_counts();
      drive(4'b0001, ~7'b1000000, 6);
      drive(4'b0010, ~7'b1111111, 6);
      check("al_zero", 32'(dv_code[0]), 32'h0);
      check("al_blank", 32'(dv_code[1]), 32'hB);
`endif

      // Randomized scan traffic checked by the model.
      for (int seg_i = 0; seg_i < 400; seg_i++) begin
         logic [ND-1:0] s;
         logic [6:0]    p;
         int            r;
         r = $urandom_range(0, 9);
         if (r < 7) s = ND'(1) << $urandom_range(0, ND - 1);
         else s = ND'($urandom_range(0, 15));
         r = $urandom_range(0, 14);
         if (r < 10) p = tbl[r];
         else if (r == 10) p = 7'd0;
         else p = 7'($urandom_range(0, 127));
         rst = ($urandom_range(0, 99) == 0);
         drive(s, p, $urandom_range(1, 8));
      end
      rst = 1'b0;
      drive(4'b0000, 7'b0000000, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
